// File: rtl/mips_multicycle.sv
// mips_multicycle: multi-cycle MIPS core with a shared datapath and one
// unified word-addressed memory port using a ready handshake.
module mips_multicycle #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic          mem_ready,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic [31:0]   retired
);
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] ADDIEX = 4'd8;
  localparam logic [3:0] ADDIWB = 4'd9;
  localparam logic [3:0] BRANCH = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;
  localparam logic [3:0] HALT   = 4'd12;

  logic [3:0]    state;
  logic [3:0]    dispatch;
  logic [DW-1:0] ir, a, b, mdr, alu_out;
  logic [DW-1:0] rf [32];
  logic [5:0]    op, funct;
  logic [4:0]    rs, rt, rd;
  logic [DW-1:0] sign_imm, alu_res;
  logic          funct_ok;
  logic          rf_we;
  logic [4:0]    rf_wa;
  logic [DW-1:0] rf_wd;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign sign_imm = {{(DW-16){ir[15]}}, ir[15:0]};

  always_comb begin
    alu_res  = '0;
    funct_ok = 1'b1;
    case (funct)
      6'h20:   alu_res = a + b;
      6'h22:   alu_res = a - b;
      6'h24:   alu_res = a & b;
      6'h25:   alu_res = a | b;
      6'h2A:   alu_res = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    dispatch = HALT;
    case (op)
      6'h00:        dispatch = funct_ok ? EXEC : HALT;
      6'h23, 6'h2B: dispatch = MEMADR;
      6'h04:        dispatch = BRANCH;
      6'h08:        dispatch = ADDIEX;
      6'h02:        dispatch = JUMP;
      default:      dispatch = HALT;
    endcase
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wa = rt;
    rf_wd = alu_out;
    case (state)
      MEMWB:  begin rf_we = 1'b1; rf_wd = mdr; end
      ALUWB:  begin rf_we = 1'b1; rf_wa = rd; end
      ADDIWB: rf_we = 1'b1;
      default: ;
    endcase
  end

  // Requests are gated by clr so an aborted access drops immediately
  assign mem_re    = !clr && (state == FETCH || state == MEMRD);
  assign mem_we    = !clr && (state == MEMWR);
  assign mem_addr  = (state == FETCH) ? pc : alu_out[AW-1:0];
  assign mem_wdata = b;
  assign halted    = !clr && (state == HALT);

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= FETCH;
      pc      <= '0;
      retired <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      mdr     <= '0;
      alu_out <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
      case (state)
        FETCH: if (mem_ready) begin
          ir    <= mem_rdata;
          pc    <= pc + AW'(1);
          state <= DECODE;
        end
        DECODE: begin
          a     <= rf[rs];
          b     <= rf[rt];
          state <= dispatch;
        end
        MEMADR: begin
          alu_out <= a + sign_imm;
          state   <= (op == 6'h23) ? MEMRD : MEMWR;
        end
        MEMRD: if (mem_ready) begin
          mdr   <= mem_rdata;
          state <= MEMWB;
        end
        MEMWR: if (mem_ready) begin
          retired <= retired + 32'd1;
          state   <= FETCH;
        end
        EXEC: begin
          alu_out <= alu_res;
          state   <= ALUWB;
        end
        ADDIEX: begin
          alu_out <= a + sign_imm;
          state   <= ADDIWB;
        end
        MEMWB, ALUWB, ADDIWB: begin
          retired <= retired + 32'd1;
          state   <= FETCH;
        end
        BRANCH: begin
          if (a == b) pc <= pc + sign_imm[AW-1:0];
          retired <= retired + 32'd1;
          state   <= FETCH;
        end
        JUMP: begin
          pc      <= ir[AW-1:0];
          retired <= retired + 32'd1;
          state   <= FETCH;
        end
        HALT: ;
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: unified memory model with programmable wait states,
// retirement and store scoreboards for the multi-cycle MIPS core.
module tb_mips_multicycle;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] pc;
  logic          halted;
  logic [31:0]   retired;

  mips_multicycle #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .clr(clr),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_re(mem_re),
    .mem_we(mem_we), .mem_ready(mem_ready),
    .pc(pc), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  typedef struct {
    logic [AW-1:0] pc;
    int            cyc;
  } ret_t;

  logic [DW-1:0] img [64];
  logic [DW-1:0] mem [64];
  wr_t  obs_q[$];
  wr_t  exp_wr_q[$];
  ret_t exp_ret_q[$];
  int   wait_n = 0;
  int   wcnt = 0;
  int   both_cnt = 0;
  int   unstable_cnt = 0;
  logic          prev_pend = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wd = '0;
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [31:0] HALT_I = {6'h3F, 26'd0};

  assign mem_ready = (wcnt >= wait_n);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (clr) mem <= img;
    else if (mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
    if (mem_we && mem_ready) obs_q.push_back('{mem_addr, mem_wdata});
    if (clr || !(mem_re || mem_we) || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (mem_re && mem_we) both_cnt <= both_cnt + 1;
    if (prev_pend && (mem_re || mem_we) &&
        (mem_addr != prev_addr || mem_wdata != prev_wd))
      unstable_cnt <= unstable_cnt + 1;
    prev_pend <= (mem_re || mem_we) && !mem_ready;
    prev_addr <= mem_addr;
    prev_wd   <= mem_wdata;
  end

  function automatic logic [31:0] ei(int op, int rs, int rt, int imm);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] er(int rs, int rt, int rd, int fn);
    logic [31:0] w;
    w = {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    return w;
  endfunction

  function automatic logic [31:0] ej(int t);
    logic [31:0] w;
    w = {6'h02, t[25:0]};
    return w;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = '0;
    exp_ret_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic push_ret(input int p, input int c);
    ret_t e;
    e.pc  = p[AW-1:0];
    e.cyc = c;
    exp_ret_q.push_back(e);
  endtask

  task automatic push_wr(input int ad, input logic [DW-1:0] d);
    wr_t e;
    e.addr = ad[AW-1:0];
    e.data = d;
    exp_wr_q.push_back(e);
  endtask

  task automatic apply_reset(input int wn);
    @(negedge clk);
    clr = 1'b1;
    wait_n = wn;
    repeat (2) @(negedge clk);
    obs_q.delete();
  endtask

  // Releases clr and scores every retirement until halted or budget runs out
  task automatic run_prog(input int budget, output int halt_cyc);
    int   cyc;
    int   last_ret;
    ret_t e;
    clr = 1'b0;
    cyc = 0;
    last_ret = 0;
    halt_cyc = -1;
    while (cyc < budget && halt_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (retired != last_ret) begin
        last_ret = int'(retired);
        n_checks++;
        if (exp_ret_q.size() == 0) begin
          n_fail++;
          $display("FAIL retire_extra: got retirement %0d at pc %0d, required none",
                   last_ret, pc);
        end else begin
          e = exp_ret_q.pop_front();
          if (pc !== e.pc || (e.cyc >= 0 && cyc - 1 != e.cyc)) begin
            n_fail++;
            $display("FAIL retire_%0d: got pc %0d cycle %0d, required pc %0d cycle %0d",
                     last_ret, pc, cyc - 1, e.pc, e.cyc);
          end
        end
      end
      if (halted) halt_cyc = cyc;
    end
    n_checks++;
    if (halt_cyc < 0 || exp_ret_q.size() != 0) begin
      n_fail++;
      $display("FAIL run_end: got halt cycle %0d with %0d retirements pending, required halt and 0 pending",
               halt_cyc, exp_ret_q.size());
    end
    while (exp_wr_q.size() != 0) begin
      wr_t x;
      wr_t o;
      x = exp_wr_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL store_missing: got none, required mem[%0d]=%h", x.addr, x.data);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== x.addr || o.data !== x.data) begin
          n_fail++;
          $display("FAIL store: got mem[%0d]=%h, required mem[%0d]=%h",
                   o.addr, o.data, x.addr, x.data);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL store_extra: got %0d unexpected stores, required 0", obs_q.size());
    end
  endtask

  task automatic test_reset();
    clear_img();
    img[0] = HALT_I;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pc !== '0 || retired !== '0 || mem_re !== 1'b0 ||
        mem_we !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%0d ret=%0d re=%b we=%b h=%b, required all 0",
               pc, retired, mem_re, mem_we, halted);
    end
    clr = 1'b0;
    #1;
    n_checks++;
    if (mem_re !== 1'b1 || mem_addr !== '0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fetch: got re=%b we=%b addr=%0d, required re=1 we=0 addr=0",
               mem_re, mem_we, mem_addr);
    end
  endtask

  task automatic test_basic();
    int hc;
    clear_img();
    img[0] = ei(8, 0, 1, 5);
    img[1] = ei(8, 0, 2, -3);
    img[2] = er(1, 2, 3, 'h20);
    img[3] = HALT_I;
    push_ret(1, 3);
    push_ret(2, 7);
    push_ret(3, 11);
    apply_reset(0);
    run_prog(60, hc);
    n_checks++;
    if (hc != 14 || retired !== 32'd3 || dut.rf[3] !== 32'd2) begin
      n_fail++;
      $display("FAIL basic: got halt@%0d ret=%0d r3=%h, required halt@14 ret=3 r3=2",
               hc, retired, dut.rf[3]);
    end
  endtask

  task automatic test_mem_wait();
    int hc;
    int b0;
    int u0;
    clear_img();
    img[0] = ei(8, 0, 3, 2);
    img[1] = ei('h2B, 0, 3, 40);
    img[2] = ei('h23, 0, 4, 40);
    img[3] = ei('h2B, 0, 4, 41);
    img[4] = HALT_I;
    push_ret(1, 5);
    push_ret(2, 13);
    push_ret(3, 22);
    push_ret(4, 30);
    push_wr(40, 32'd2);
    push_wr(41, 32'd2);
    apply_reset(2);
    b0 = both_cnt;
    u0 = unstable_cnt;
    run_prog(120, hc);
    n_checks++;
    if (mem[40] !== 32'd2 || retired !== 32'd4) begin
      n_fail++;
      $display("FAIL mem_wait: got mem40=%h ret=%0d, required mem40=2 ret=4",
               mem[40], retired);
    end
    n_checks++;
    if (both_cnt != b0 || unstable_cnt != u0) begin
      n_fail++;
      $display("FAIL handshake: got both=%0d unstable=%0d, required 0 and 0",
               both_cnt - b0, unstable_cnt - u0);
    end
  endtask

  task automatic test_branch();
    int hc;
    clear_img();
    img[0] = ei(8, 0, 1, 3);
    img[1] = ei(8, 0, 2, 3);
    img[2] = ei(4, 1, 0, 7);
    img[3] = ej(5);
    img[4] = HALT_I;
    img[5] = ei(4, 1, 2, -2);
    push_ret(1, 3);
    push_ret(2, 7);
    push_ret(3, 10);
    push_ret(5, 13);
    push_ret(4, 16);
    apply_reset(0);
    run_prog(60, hc);
  endtask

  task automatic test_alu();
    int hc;
    clear_img();
    img[0]  = ei(8, 0, 1, -1);
    img[1]  = ei(8, 0, 2, 1);
    img[2]  = er(1, 2, 3, 'h2A);
    img[3]  = er(0, 2, 4, 'h22);
    img[4]  = ei(8, 0, 0, 7);
    img[5]  = ei(8, 0, 7, 'hF0);
    img[6]  = er(1, 7, 5, 'h24);
    img[7]  = er(7, 2, 6, 'h25);
    img[8]  = er(2, 1, 8, 'h2A);
    img[9]  = ei('h2B, 0, 3, 40);
    img[10] = ei('h2B, 0, 4, 41);
    img[11] = ei('h2B, 0, 0, 42);
    img[12] = ei('h2B, 0, 5, 43);
    img[13] = ei('h2B, 0, 6, 44);
    img[14] = ei('h2B, 0, 8, 45);
    img[15] = HALT_I;
    for (int i = 0; i < 15; i++) push_ret(i + 1, 4 * (i + 1) - 1);
    push_wr(40, 32'd1);
    push_wr(41, 32'hFFFF_FFFF);
    push_wr(42, 32'd0);
    push_wr(43, 32'h0000_00F0);
    push_wr(44, 32'h0000_00F1);
    push_wr(45, 32'd0);
    apply_reset(0);
    run_prog(120, hc);
  endtask

  task automatic test_jump_wrap();
    int hc;
    clear_img();
    img[0]  = ei(4, 1, 0, 1);
    img[1]  = HALT_I;
    img[2]  = ej(63);
    img[63] = ei(8, 0, 1, 9);
    push_ret(2, 2);
    push_ret(63, 5);
    push_ret(0, 9);
    push_ret(1, 12);
    apply_reset(0);
    run_prog(60, hc);
  endtask

  task automatic test_clr_abort();
    int cyc;
    clear_img();
    img[0] = ei(8, 0, 3, 7);
    img[1] = ei('h2B, 0, 3, 40);
    img[2] = HALT_I;
    apply_reset(3);
    clr = 1'b0;
    cyc = 0;
    while (cyc < 40 && mem_we !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (mem_we !== 1'b1 || mem_ready !== 1'b0 || retired !== 32'd1) begin
      n_fail++;
      $display("FAIL abort_setup: got we=%b ready=%b ret=%0d, required we=1 ready=0 ret=1",
               mem_we, mem_ready, retired);
    end
    clr = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_req: got we=%b re=%b, required we=0 re=0", mem_we, mem_re);
    end
    @(negedge clk);
    n_checks++;
    if (pc !== '0 || retired !== '0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_state: got pc=%0d ret=%0d stores=%0d, required 0 0 0",
               pc, retired, obs_q.size());
    end
  endtask

  task automatic test_undef();
    int hc;
    clear_img();
    img[0] = ei(8, 0, 1, 1);
    img[1] = {6'h3E, 26'd0};
    img[2] = ei(8, 0, 1, 2);
    push_ret(1, 3);
    apply_reset(0);
    run_prog(40, hc);
    repeat (5) @(negedge clk);
    n_checks++;
    if (hc != 6 || halted !== 1'b1 || retired !== 32'd1 || pc !== 6'd2) begin
      n_fail++;
      $display("FAIL undef: got halt@%0d h=%b ret=%0d pc=%0d, required halt@6 h=1 ret=1 pc=2",
               hc, halted, retired, pc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_wait();
    test_branch();
    test_alu();
    test_jump_wrap();
    test_clr_abort();
    test_undef();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Parametrised multi-cycle MIPS core: the successor to the single-cycle processor. It executes one instruction over 3–5 states of an FSM with a shared datapath. A single unified, word-addressed memory port with a ready handshake replaces the separate instruction and data memories. It sits between the existing ALU, register-file and memory models and the top-level bench, and adds wait-state tolerance, `beq`, `addi`, `j`, a halt instruction and a retired-instruction counter.

## Interface
- `AW`, default 6: word-address width of the memory port and PC.
- `DW`, default 32: datapath, register and memory word width (ISA fields assume 32).
- `clk`  in  1: clock, rising edge.
- `clr`  in  1: synchronous, active-high reset.
- `mem_addr`  out  AW: word address; PC in fetch states, ALU result in memory states.
- `mem_rdata`  in  DW: read data, valid when `mem_ready`=1 during a read.
- `mem_wdata`  out  DW: store data (rt register value).
- `mem_re`  out  1: read request.
- `mem_we`  out  1: write request; never asserted together with `mem_re`.
- `mem_ready`  in  1: completes the current request in the cycle it is sampled high.
- `pc`  out  AW: current instruction address.
- `halted`  out  1: high in HALT state.
- `retired`  out  32: count of completed instructions; wraps modulo 2^32.

## Operation
- ISA:
  - R-type (op 0): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Other opcodes: lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02, halt 0x3F.
  - Any other opcode or funct: enter HALT.
- Registers: 32 x DW. `$0` always reads 0; writes to it are discarded. Reset clears all registers.
- Arithmetic: all DW-bit, wrap on overflow with no trap. slt is signed. Immediates are sign-extended to DW.
- Addresses:
  - Data address = (rs + signimm)[AW-1:0].
  - Branch target = pc + 1 + signimm, truncated to AW and wrapping.
  - Jump target = instr[AW-1:0].
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT.
  - FETCH: `mem_re`=1, `mem_addr`=pc. Hold until `mem_ready`, then latch IR, set pc<=pc+1, and go to DECODE.
  - DECODE: read rs/rt into A/B, then dispatch on opcode.
  - lw: MEMADR -> MEMRD (`mem_re`, hold until ready, latch MDR) -> MEMWB (rt<=MDR) -> FETCH.
  - sw: MEMADR -> MEMWR (`mem_we`, hold until ready) -> FETCH.
  - R-type: EXEC -> ALUWB (rd<=ALUOut) -> FETCH.
  - addi: ADDIEX -> ADDIWB (rt<=ALUOut) -> FETCH.
  - beq: BRANCH. If A==B, pc<=target. Then FETCH.
  - j: JUMP sets pc<=target, then FETCH.
  - HALT: terminal. Only `clr` exits it. `retired` does not count the halt instruction.
- `retired` increments once, on the final cycle of each completed instruction: writeback, MEMWR with ready, BRANCH or JUMP.
- Memory outputs are Moore outputs of the state. `mem_addr` and `mem_wdata` stay stable while a request waits for ready.

## Timing
- While `clr`=1: state<=FETCH, pc<=0, retired<=0, registers<=0, `mem_re`=`mem_we`=`halted`=0.
- First fetch: `mem_re`=1, `mem_addr`=0 in the first cycle after `clr` falls.
- Latency with `mem_ready` tied 1: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3 cycles.
- Each low cycle of `mem_ready` adds one cycle in FETCH, MEMRD or MEMWR.
- Write port: a register write occurs at the clock edge ending MEMWB, ALUWB or ADDIWB. DECODE of the next instruction sees the new value.
- `clr` mid-instruction aborts it immediately, including a pending memory request. No write is performed at that edge.
- pc wraps from 2^AW-1 to 0.

## Test plan
- Reset, `mem_ready`=1, program `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; halt` -> $3=2, `retired`=3, `halted` high at cycle 14.
- `sw $3,4($0); lw $4,4($0)` with `mem_ready` low 2 cycles on every request -> mem[4]=2, $4=2. Address and data stay stable during the wait. `mem_we`/`mem_re` are never both high.
- `beq` taken (equal regs, imm=-2) and not taken -> pc goes to pc+1-2 and pc+1 respectively. Each takes 3 cycles.
- `slt` with 0xFFFFFFFF vs 1 -> 1. `sub` 0 - 1 -> 0xFFFFFFFF. `addi $0,$0,7` -> $0 still reads 0.
- `j` to 0x3F with AW=6, then fetch at 63 followed by an instruction fall-through -> pc wraps to 0.
- `clr` asserted during MEMWR wait -> no write occurs. Next cycle shows pc=0 and `retired`=0. Undefined opcode 0x3E -> `halted`=1 with `retired` unchanged.
